branch_resolve_ctrl: RTL and testbench

- Sequences the ID-stage branch comparator (16-bit subtract-and-OR not-equal flag) for BEQ/BNE in the 16-bit pipelined MIPS datapath.
- Detects data hazards on the comparator operands, stalls the front end for the required cycles, and steers forwarding muxes feeding the comparator.
- Resolves the branch and drives PC redirect plus IF/ID flush.
- Keeps branch/taken statistics counters.

---
 rtl/branch_resolve_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller for the ID-stage BEQ/BNE comparator.
// Detects operand hazards, stalls the front end and steers the comparator
// forwarding muxes. It then resolves the branch, drives the PC redirect and
// IF/ID flush, and keeps saturating branch and taken statistics.
module branch_resolve_ctrl #(
    parameter int unsigned DW  = 16,
    parameter int unsigned RAW = 3,
    parameter int unsigned CW  = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_id_valid,
    input  logic           i_id_is_beq,
    input  logic           i_id_is_bne,
    input  logic [RAW-1:0] i_id_rs,
    input  logic [RAW-1:0] i_id_rt,
    input  logic [DW-1:0]  i_id_pc_plus1,
    input  logic [DW-1:0]  i_id_offset,
    input  logic           i_ex_regwrite,
    input  logic           i_ex_memread,
    input  logic [RAW-1:0] i_ex_rd,
    input  logic           i_mem_regwrite,
    input  logic           i_mem_memread,
    input  logic [RAW-1:0] i_mem_rd,
    input  logic           i_wb_regwrite,
    input  logic [RAW-1:0] i_wb_rd,
    input  logic           i_cmp_ne,
    output logic           o_stall,
    output logic           o_flush_ifid,
    output logic           o_pc_src,
    output logic [DW-1:0]  o_branch_target,
    output logic [1:0]     o_fwd_a_sel,
    output logic [1:0]     o_fwd_b_sel,
    output logic [CW-1:0]  o_branch_cnt,
    output logic [CW-1:0]  o_taken_cnt
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StStall    = 2'd1,
        StRedirect = 2'd2
    } state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic [1:0]      r_stall_cnt;
    logic [1:0]      w_stall_cnt_d;
    logic [CW-1:0]   r_branch_cnt;
    logic [CW-1:0]   r_taken_cnt;
    logic [CW-1:0]   w_branch_cnt_d;
    logic [CW-1:0]   w_taken_cnt_d;

    logic            w_br;
    logic            w_dep_ex;
    logic            w_dep_mem;
    logic [1:0]      w_n;
    logic            w_taken;
    logic            w_eval;
    logic            w_stall;
    logic [1:0]      w_fwd_a;
    logic [1:0]      w_fwd_b;
    logic [DW-1:0]   w_target;

    // A producer matters only if it writes a non-zero register used by the branch.
    function automatic logic dep(input logic [RAW-1:0] rd, input logic [RAW-1:0] rs,
                                 input logic [RAW-1:0] rt);
        return (rd != '0) && ((rd == rs) || (rd == rt));
    endfunction

    // MEM-stage ALU result has priority over the older WB value.
    function automatic logic [1:0] fwd_sel(input logic [RAW-1:0] op);
        if (i_mem_regwrite && !i_mem_memread && (i_mem_rd == op) && (op != '0)) begin
            return 2'b01;
        end else if (i_wb_regwrite && (i_wb_rd == op) && (op != '0)) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    assign w_br      = i_id_valid & (i_id_is_beq | i_id_is_bne);
    assign w_dep_ex  = dep(i_ex_rd, i_id_rs, i_id_rt);
    assign w_dep_mem = dep(i_mem_rd, i_id_rs, i_id_rt);
    assign w_taken   = i_id_is_beq ? ~i_cmp_ne : i_cmp_ne;
    assign w_target  = i_id_pc_plus1 + i_id_offset;
    assign w_fwd_a   = fwd_sel(i_id_rs);
    assign w_fwd_b   = fwd_sel(i_id_rt);

    // Stall length required before the comparator operands are forwardable.
    always_comb begin
        w_n = 2'd0;
        if (i_ex_regwrite && i_ex_memread && w_dep_ex) begin
            w_n = 2'd2;
        end else if (i_ex_regwrite && w_dep_ex) begin
            w_n = 2'd1;
        end else if (i_mem_regwrite && i_mem_memread && w_dep_mem) begin
            w_n = 2'd1;
        end
    end

    // Next-state, stall and evaluate decisions.
    always_comb begin
        w_state_d     = r_state;
        w_stall_cnt_d = r_stall_cnt;
        w_stall       = 1'b0;
        w_eval        = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_br) begin
                    if (w_n != 2'd0) begin
                        w_stall       = 1'b1;
                        w_state_d     = StStall;
                        w_stall_cnt_d = w_n - 2'd1;
                    end else begin
                        w_eval = 1'b1;
                    end
                end
            end
            StStall: begin
                if (r_stall_cnt != 2'd0) begin
                    w_stall       = 1'b1;
                    w_stall_cnt_d = r_stall_cnt - 2'd1;
                end else if (!w_br) begin
                    w_state_d = StIdle;
                end else if (w_n != 2'd0) begin
                    // Hazard still visible: keep holding until operands are ready.
                    w_stall = 1'b1;
                end else begin
                    w_eval = 1'b1;
                end
            end
            StRedirect: begin
                // ID holds the flushed bubble; id_* inputs are meaningless here.
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
        if (w_eval) begin
            w_state_d = w_taken ? StRedirect : StIdle;
        end
    end

    // Saturating statistics counters advance on every resolution.
    always_comb begin
        w_branch_cnt_d = r_branch_cnt;
        w_taken_cnt_d  = r_taken_cnt;
        if (w_eval) begin
            if (r_branch_cnt != '1) begin
                w_branch_cnt_d = r_branch_cnt + CW'(1);
            end
            if (w_taken && (r_taken_cnt != '1)) begin
                w_taken_cnt_d = r_taken_cnt + CW'(1);
            end
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_stall_cnt  <= 2'd0;
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else begin
            r_state      <= w_state_d;
            r_stall_cnt  <= w_stall_cnt_d;
            r_branch_cnt <= w_branch_cnt_d;
            r_taken_cnt  <= w_taken_cnt_d;
        end
    end

    // Outputs, all forced low while reset is held.
    always_comb begin
        o_stall         = 1'b0;
        o_flush_ifid    = 1'b0;
        o_pc_src        = 1'b0;
        o_branch_target = '0;
        o_fwd_a_sel     = 2'b00;
        o_fwd_b_sel     = 2'b00;
        o_branch_cnt    = '0;
        o_taken_cnt     = '0;
        if (!i_rst) begin
            o_stall         = w_stall;
            o_flush_ifid    = w_eval & w_taken;
            o_pc_src        = w_eval & w_taken;
            o_branch_target = w_target;
            o_fwd_a_sel     = w_eval ? w_fwd_a : 2'b00;
            o_fwd_b_sel     = w_eval ? w_fwd_b : 2'b00;
            o_branch_cnt    = r_branch_cnt;
            o_taken_cnt     = r_taken_cnt;
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: per-cycle stimulus rows, expected
// outputs pushed to a scoreboard when driven and popped when the outputs settle.
module tb_branch_resolve_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid, id_is_beq, id_is_bne;
    logic [2:0]  id_rs, id_rt;
    logic [15:0] id_pc_plus1, id_offset;
    logic        ex_regwrite, ex_memread;
    logic [2:0]  ex_rd;
    logic        mem_regwrite, mem_memread;
    logic [2:0]  mem_rd;
    logic        wb_regwrite;
    logic [2:0]  wb_rd;
    logic        cmp_ne;
    logic        o_stall, o_flush, o_pc_src;
    logic [15:0] o_tgt;
    logic [1:0]  o_fa, o_fb;
    logic [15:0] o_bc, o_tc;

    branch_resolve_ctrl #(.DW(16), .RAW(3), .CW(16)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_valid(id_valid), .i_id_is_beq(id_is_beq), .i_id_is_bne(id_is_bne),
        .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_pc_plus1(id_pc_plus1), .i_id_offset(id_offset),
        .i_ex_regwrite(ex_regwrite), .i_ex_memread(ex_memread), .i_ex_rd(ex_rd),
        .i_mem_regwrite(mem_regwrite), .i_mem_memread(mem_memread), .i_mem_rd(mem_rd),
        .i_wb_regwrite(wb_regwrite), .i_wb_rd(wb_rd), .i_cmp_ne(cmp_ne),
        .o_stall(o_stall), .o_flush_ifid(o_flush), .o_pc_src(o_pc_src),
        .o_branch_target(o_tgt), .o_fwd_a_sel(o_fa), .o_fwd_b_sel(o_fb),
        .o_branch_cnt(o_bc), .o_taken_cnt(o_tc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst, valid, beq, bne;
        logic [2:0]  rs, rt;
        logic [15:0] pc, off;
        logic        cmp;
        logic        ex_rw, ex_mr;
        logic [2:0]  ex_rd;
        logic        mem_rw, mem_mr;
        logic [2:0]  mem_rd;
        logic        wb_rw;
        logic [2:0]  wb_rd;
    } stim_t;

    typedef struct packed {
        logic        stall, flush, pc_src;
        logic [15:0] tgt;
        logic        chk;
        logic [1:0]  fa, fb;
        logic        ev;
    } exp_t;

    typedef struct packed {
        exp_t        e;
        logic [15:0] bc, tc;
    } sb_t;

    sb_t         sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [15:0] m_b = 16'h0;
    logic [15:0] m_t = 16'h0;

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'h1;
    endfunction

    function automatic stim_t st(input logic valid, input logic beq, input logic bne,
                                 input logic [2:0] rs, input logic [2:0] rt,
                                 input logic [15:0] pc, input logic [15:0] off,
                                 input logic cmp);
        stim_t s;
        s = '0;
        s.valid = valid; s.beq = beq; s.bne = bne; s.rs = rs; s.rt = rt;
        s.pc = pc; s.off = off; s.cmp = cmp;
        return s;
    endfunction

    function automatic exp_t ex(input logic stall, input logic flush, input logic pcs,
                                input logic [15:0] tgt, input logic chk,
                                input logic [1:0] fa, input logic [1:0] fb, input logic ev);
        exp_t e;
        e.stall = stall; e.flush = flush; e.pc_src = pcs; e.tgt = tgt; e.chk = chk;
        e.fa = fa; e.fb = fb; e.ev = ev;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        rst = s.rst; id_valid = s.valid; id_is_beq = s.beq; id_is_bne = s.bne;
        id_rs = s.rs; id_rt = s.rt; id_pc_plus1 = s.pc; id_offset = s.off; cmp_ne = s.cmp;
        ex_regwrite = s.ex_rw; ex_memread = s.ex_mr; ex_rd = s.ex_rd;
        mem_regwrite = s.mem_rw; mem_memread = s.mem_mr; mem_rd = s.mem_rd;
        wb_regwrite = s.wb_rw; wb_rd = s.wb_rd;
    endtask

    task automatic push_exp(input stim_t s, input exp_t e);
        sb_t t;
        if (s.rst) begin
            m_b = 16'h0;
            m_t = 16'h0;
        end
        t.e = e; t.bc = m_b; t.tc = m_t;
        sb.push_back(t);
    endtask

    task automatic retire(input sb_t c);
        if (c.e.ev) begin
            m_b = sat(m_b);
            if (c.e.pc_src) m_t = sat(m_t);
        end
    endtask

    task automatic test_reset();
        stim_t s[3]; exp_t e[3]; sb_t c;
        s[0] = st(1, 0, 1, 3'd1, 3'd2, 16'h0010, 16'h0004, 1); s[0].rst = 1;
        s[1] = s[0];
        s[2] = st(0, 0, 0, 3'd0, 3'd0, 16'h0, 16'h0, 0);
        e[0] = ex(0, 0, 0, 16'h0, 1, 2'b00, 2'b00, 0);
        e[1] = e[0];
        e[2] = ex(0, 0, 0, 16'h0, 1, 2'b00, 2'b00, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); apply(s[i]); push_exp(s[i], e[i]); #1;
            c = sb.pop_front(); n_cmp++;
            if ({o_stall, o_flush, o_pc_src, o_fa, o_fb, o_bc, o_tc} !==
                {c.e.stall, c.e.flush, c.e.pc_src, c.e.fa, c.e.fb, c.bc, c.tc} ||
                (c.e.chk && o_tgt !== c.e.tgt)) begin
                n_fail++;
                $display("FAIL reset[%0d]: got st=%b fl=%b pc=%b tg=%h fa=%b fb=%b bc=%h tc=%h want st=%b fl=%b pc=%b tg=%h fa=%b fb=%b bc=%h tc=%h",
                         i, o_stall, o_flush, o_pc_src, o_tgt, o_fa, o_fb, o_bc, o_tc,
                         c.e.stall, c.e.flush, c.e.pc_src, c.e.tgt, c.e.fa, c.e.fb, c.bc, c.tc);
            end
            retire(c);
        end
    endtask

    task automatic test_no_hazard();
        stim_t s[3]; exp_t e[3]; sb_t c;
        s[0] = st(1, 0, 1, 3'd1, 3'd2, 16'h0010, 16'h0004, 1);
        s[1] = s[0];  // REDIRECT ignores the still-present branch
        s[2] = st(0, 0, 0, 3'd0, 3'd0, 16'h0, 16'h0, 0);
        e[0] = ex(0, 1, 1, 16'h0014, 1, 2'b00, 2'b00, 1);
        e[1] = ex(0, 0, 0, 16'h0, 0, 2'b00, 2'b00, 0);
        e[2] = ex(0, 0, 0, 16'h0, 0, 2'b00, 2'b00, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); apply(s[i]); push_exp(s[i], e[i]); #1;
            c = sb.pop_front(); n_cmp++;
            if ({o_stall, o_flush, o_pc_src, o_fa, o_fb, o_bc, o_tc} !==
                {c.e.stall, c.e.flush, c.e.pc_src, c.e.fa, c.e.fb, c.bc, c.tc} ||
                (c.e.chk && o_tgt !== c.e.tgt)) begin
                n_fail++;
                $display("FAIL no_hazard[%0d]: got st=%b fl=%b pc=%b tg=%h fa=%b fb=%b bc=%h tc=%h want st=%b fl=%b pc=%b tg=%h fa=%b fb=%b bc=%h tc=%h",
                         i, o_stall, o_flush, o_pc_src, o_tgt, o_fa, o_fb, o_bc, o_tc,
                         c.e.stall, c.e.flush, c.e.pc_src, c.e.tgt, c.e.fa, c.e.fb, c.bc, c.tc);
            end
            retire(c);
        end
    endtask

    task automatic test_load_use();
        stim_t s[5]; exp_t e[5]; sb_t c;
        s[0] = st(1, 1, 0, 3'd3, 3'd5, 16'h0020, 16'hFFF0, 0);
        s[0].ex_rw = 1; s[0].ex_mr = 1; s[0].ex_rd = 3'd3;
        s[1] = st(1, 1, 0, 3'd3, 3'd5, 16'h0020, 16'hFFF0, 0);
        s[1].mem_rw = 1; s[1].mem_mr = 1; s[1].mem_rd = 3'd3;
        s[2] = st(1, 1, 0, 3'd3, 3'd5, 16'h0020, 16'hFFF0, 0);
        s[2].wb_rw = 1; s[2].wb_rd = 3'd3;
        s[3] = st(0, 0, 0, 3'd0, 3'd0, 16'h0, 16'h0, 0);
        s[4] = s[3];
        e[0] = ex(1, 0, 0, 16'h0, 0, 2'b00, 2'b00, 0);
        e[1] = e[0];
        e[2] = ex(0, 1, 1, 16'h0010, 1, 2'b10, 2'b00, 1);
        e[3] = ex(0, 0, 0, 16'h0, 0, 2'b00, 2'b00, 0);
        e[4] = e[3];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); apply(s[i]); push_exp(s[i], e[i]); #1;
            c = sb.pop_front(); n_cmp++;
            if ({o_stall, o_flush, o_pc_src, o_fa, o_fb, o_bc, o_tc} !==
                {c.e.stall, c.e.flush, c.e.pc_src, c.e.fa, c.e.fb, c.bc, c.tc} ||
                (c.e.chk && o_tgt !== c.e.tgt)) begin
                n_fail++;
                $display("FAIL load_use[%0d]: got st=%b fl=%b pc=%b tg=%h fa=%b fb=%b bc=%h tc=%h want st=%b fl=%b pc=%b tg=%h fa=%b fb=%b bc=%h tc=%h",
                         i, o_stall, o_flush, o_pc_src, o_tgt, o_fa, o_fb, o_bc, o_tc,
                         c.e.stall, c.e.flush, c.e.pc_src, c.e.tgt, c.e.fa, c.e.fb, c.bc, c.tc);
            end
            retire(c);
        end
    endtask

    task automatic test_ex_alu();
        stim_t s[3]; exp_t e[3]; sb_t c;
        s[0] = st(1, 0, 1, 3'd1, 3'd4, 16'h0030, 16'h0002, 0);
        s[0].ex_rw = 1; s[0].ex_rd = 3'd4;
        s[1] = st(1, 0, 1, 3'd1, 3'd4, 16'h0030, 16'h0002, 0);
        s[1].mem_rw = 1; s[1].mem_rd = 3'd4;
        s[2] = st(0, 0, 0, 3'd0, 3'd0, 16'h0, 16'h0, 0);
        e[0] = ex(1, 0, 0, 16'h0, 0, 2'b00, 2'b00, 0);
        e[1] = ex(0, 0, 0, 16'h0032, 1, 2'b00, 2'b01, 1);
        e[2] = ex(0, 0, 0, 16'h0, 0, 2'b00, 2'b00, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); apply(s[i]); push_exp(s[i], e[i]); #1;
            c = sb.pop_front(); n_cmp++;
            if ({o_stall, o_flush, o_pc_src, o_fa, o_fb, o_bc, o_tc} !==
                {c.e.stall, c.e.flush, c.e.pc_src, c.e.fa, c.e.fb, c.bc, c.tc} ||
                (c.e.chk && o_tgt !== c.e.tgt)) begin
                n_fail++;
                $display("FAIL ex_alu[%0d]: got st=%b fl=%b pc=%b tg=%h fa=%b fb=%b bc=%h tc=%h want st=%b fl=%b pc=%b tg=%h fa=%b fb=%b bc=%h tc=%h",
                         i, o_stall, o_flush, o_pc_src, o_tgt, o_fa, o_fb, o_bc, o_tc,
                         c.e.stall, c.e.flush, c.e.pc_src, c.e.tgt, c.e.fa, c.e.fb, c.bc, c.tc);
            end
            retire(c);
        end
    endtask

    task automatic test_rd_zero();
        stim_t s[2]; exp_t e[2]; sb_t c;
        s[0] = st(1, 1, 0, 3'd0, 3'd2, 16'h0050, 16'h0008, 1);
        s[0].ex_rw = 1; s[0].ex_mr = 1; s[0].ex_rd = 3'd0;
        s[0].mem_rw = 1; s[0].mem_rd = 3'd0; s[0].wb_rw = 1; s[0].wb_rd = 3'd0;
        s[1] = st(0, 0, 0, 3'd0, 3'd0, 16'h0, 16'h0, 0);
        e[0] = ex(0, 0, 0, 16'h0058, 1, 2'b00, 2'b00, 1);
        e[1] = ex(0, 0, 0, 16'h0, 0, 2'b00, 2'b00, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); apply(s[i]); push_exp(s[i], e[i]); #1;
            c = sb.pop_front(); n_cmp++;
            if ({o_stall, o_flush, o_pc_src, o_fa, o_fb, o_bc, o_tc} !==
                {c.e.stall, c.e.flush, c.e.pc_src, c.e.fa, c.e.fb, c.bc, c.tc} ||
                (c.e.chk && o_tgt !== c.e.tgt)) begin
                n_fail++;
                $display("FAIL rd_zero[%0d]: got st=%b fl=%b pc=%b tg=%h fa=%b fb=%b bc=%h tc=%h want st=%b fl=%b pc=%b tg=%h fa=%b fb=%b bc=%h tc=%h",
                         i, o_stall, o_flush, o_pc_src, o_tgt, o_fa, o_fb, o_bc, o_tc,
                         c.e.stall, c.e.flush, c.e.pc_src, c.e.tgt, c.e.fa, c.e.fb, c.bc, c.tc);
            end
            retire(c);
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[8]; exp_t e[8]; sb_t c;
        s[0] = st(1, 1, 0, 3'd1, 3'd2, 16'h0100, 16'h0010, 0);
        s[1] = s[0];
        s[2] = st(1, 0, 1, 3'd6, 3'd6, 16'h0200, 16'hFFFF, 1);
        s[2].mem_rw = 1; s[2].mem_rd = 3'd6; s[2].wb_rw = 1; s[2].wb_rd = 3'd6;
        s[3] = s[2];
        s[4] = st(1, 1, 0, 3'd5, 3'd7, 16'h0300, 16'h0002, 1);
        s[4].wb_rw = 1; s[4].wb_rd = 3'd7;
        s[5] = st(1, 0, 1, 3'd5, 3'd1, 16'h0400, 16'h0020, 0);
        s[5].mem_rw = 1; s[5].mem_mr = 1; s[5].mem_rd = 3'd5;
        s[6] = st(1, 0, 1, 3'd5, 3'd1, 16'h0400, 16'h0020, 0);
        s[6].wb_rw = 1; s[6].wb_rd = 3'd5;
        s[7] = st(0, 0, 0, 3'd0, 3'd0, 16'h0, 16'h0, 0);
        e[0] = ex(0, 1, 1, 16'h0110, 1, 2'b00, 2'b00, 1);
        e[1] = ex(0, 0, 0, 16'h0, 0, 2'b00, 2'b00, 0);
        e[2] = ex(0, 1, 1, 16'h01FF, 1, 2'b01, 2'b01, 1);
        e[3] = e[1];
        e[4] = ex(0, 0, 0, 16'h0302, 1, 2'b00, 2'b10, 1);
        e[5] = ex(1, 0, 0, 16'h0, 0, 2'b00, 2'b00, 0);
        e[6] = ex(0, 0, 0, 16'h0420, 1, 2'b10, 2'b00, 1);
        e[7] = e[1];
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); apply(s[i]); push_exp(s[i], e[i]); #1;
            c = sb.pop_front(); n_cmp++;
            if ({o_stall, o_flush, o_pc_src, o_fa, o_fb, o_bc, o_tc} !==
                {c.e.stall, c.e.flush, c.e.pc_src, c.e.fa, c.e.fb, c.bc, c.tc} ||
                (c.e.chk && o_tgt !== c.e.tgt)) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got st=%b fl=%b pc=%b tg=%h fa=%b fb=%b bc=%h tc=%h want st=%b fl=%b pc=%b tg=%h fa=%b fb=%b bc=%h tc=%h",
                         i, o_stall, o_flush, o_pc_src, o_tgt, o_fa, o_fb, o_bc, o_tc,
                         c.e.stall, c.e.flush, c.e.pc_src, c.e.tgt, c.e.fa, c.e.fb, c.bc, c.tc);
            end
            retire(c);
        end
    endtask

    task automatic test_reset_mid_stall();
        stim_t s[4]; exp_t e[4]; sb_t c;
        s[0] = st(1, 1, 0, 3'd3, 3'd5, 16'h0060, 16'h0004, 0);
        s[0].ex_rw = 1; s[0].ex_mr = 1; s[0].ex_rd = 3'd3;
        s[1] = st(1, 1, 0, 3'd3, 3'd5, 16'h0060, 16'h0004, 0);
        s[1].mem_rw = 1; s[1].mem_mr = 1; s[1].mem_rd = 3'd3; s[1].rst = 1;
        s[2] = st(0, 0, 0, 3'd0, 3'd0, 16'h0, 16'h0, 0);
        s[3] = s[2];
        e[0] = ex(1, 0, 0, 16'h0, 0, 2'b00, 2'b00, 0);
        e[1] = ex(0, 0, 0, 16'h0, 1, 2'b00, 2'b00, 0);
        e[2] = ex(0, 0, 0, 16'h0, 0, 2'b00, 2'b00, 0);
        e[3] = e[2];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); apply(s[i]); push_exp(s[i], e[i]); #1;
            c = sb.pop_front(); n_cmp++;
            if ({o_stall, o_flush, o_pc_src, o_fa, o_fb, o_bc, o_tc} !==
                {c.e.stall, c.e.flush, c.e.pc_src, c.e.fa, c.e.fb, c.bc, c.tc} ||
                (c.e.chk && o_tgt !== c.e.tgt)) begin
                n_fail++;
                $display("FAIL reset_mid_stall[%0d]: got st=%b fl=%b pc=%b tg=%h fa=%b fb=%b bc=%h tc=%h want st=%b fl=%b pc=%b tg=%h fa=%b fb=%b bc=%h tc=%h",
                         i, o_stall, o_flush, o_pc_src, o_tgt, o_fa, o_fb, o_bc, o_tc,
                         c.e.stall, c.e.flush, c.e.pc_src, c.e.tgt, c.e.fa, c.e.fb, c.bc, c.tc);
            end
            retire(c);
        end
    endtask

    task automatic test_saturate_wrap();
        stim_t s[4]; exp_t e[4]; sb_t c; stim_t nt;
        // Back-to-back not-taken BEQs, one resolution per cycle.
        nt = st(1, 1, 0, 3'd1, 3'd2, 16'h0040, 16'h0001, 1);
        for (int k = 0; k < 65535; k++) begin
            @(negedge clk); apply(nt);
            m_b = sat(m_b);
        end
        s[0] = st(0, 0, 0, 3'd0, 3'd0, 16'h0, 16'h0, 0);
        s[1] = st(1, 1, 0, 3'd1, 3'd2, 16'hFFFE, 16'h0005, 0);
        s[2] = s[0];
        s[3] = s[0];
        e[0] = ex(0, 0, 0, 16'h0, 0, 2'b00, 2'b00, 0);
        e[1] = ex(0, 1, 1, 16'h0003, 1, 2'b00, 2'b00, 1);
        e[2] = e[0];
        e[3] = e[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); apply(s[i]); push_exp(s[i], e[i]); #1;
            c = sb.pop_front(); n_cmp++;
            if ({o_stall, o_flush, o_pc_src, o_fa, o_fb, o_bc, o_tc} !==
                {c.e.stall, c.e.flush, c.e.pc_src, c.e.fa, c.e.fb, c.bc, c.tc} ||
                (c.e.chk && o_tgt !== c.e.tgt)) begin
                n_fail++;
                $display("FAIL saturate_wrap[%0d]: got st=%b fl=%b pc=%b tg=%h fa=%b fb=%b bc=%h tc=%h want st=%b fl=%b pc=%b tg=%h fa=%b fb=%b bc=%h tc=%h",
                         i, o_stall, o_flush, o_pc_src, o_tgt, o_fa, o_fb, o_bc, o_tc,
                         c.e.stall, c.e.flush, c.e.pc_src, c.e.tgt, c.e.fa, c.e.fb, c.bc, c.tc);
            end
            retire(c);
        end
        n_cmp++;
        if (m_b !== 16'hFFFF || o_bc !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL saturate_hold: got bc=%h want bc=ffff", o_bc);
        end
    endtask

    initial begin
        clk = 1'b0;
        apply(st(0, 0, 0, 3'd0, 3'd0, 16'h0, 16'h0, 0));
        rst = 1'b1;
        test_reset();
        test_no_hazard();
        test_load_use();
        test_ex_alu();
        test_rd_zero();
        test_back_to_back();
        test_reset_mid_stall();
        test_saturate_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
